lpc_reg_arbiter: RTL and testbench
==================================

# lpc_reg_arbiter

Shares the single access port of the 32-byte LPC register file between two requesters: the LPC host cycle engine (Host) and the BMC sideband slave (Bmc). It issues one access at a time as `Addr`/`Wr`/`DataWrSW` and returns read data from the register file's read mux. It provides round-robin fairness, an optional bus lock for read-modify-write sequences, and an out-of-range error response. It sits between the requester front-ends and the register file, on the LPC clock domain.

## Interface
- NUM_REGS, 32, number of implemented register addresses (0 .. NUM_REGS-1)
- LOCK_MAX, 64, idle IDLE cycles after which an unused lock is force-released (8-bit counter, 1..255)
- LpcClock  in  1  33 MHz LPC clock; all logic on rising edge
- PciReset  in  1  reset, synchronous, active-high
- HostReq, BmcReq  in  1  access request; level, held until Ack
- HostWr, BmcWr  in  1  1 = write, 0 = read; stable while Req
- HostLock, BmcLock  in  1  keep grant after this access; stable while Req
- HostAddr, BmcAddr  in  8  register address; stable while Req
- HostWrData, BmcWrData  in  8  write data; stable while Req
- HostAck, BmcAck  out  1  one-cycle completion pulse
- HostRdData, BmcRdData  out  8  data captured for the last completed access
- HostErr, BmcErr  out  1  last completed access was out of range
- RegRdData  in  8  register file read data for current `Addr` (combinational)
- Addr  out  8  register address to register file
- Wr  out  1  one-cycle write strobe to register file
- DataWrSW  out  8  write data to register file
- Busy  out  1  FSM not in IDLE
- Owner  out  1  0 = Host, 1 = Bmc; requester of current or last grant
- LockTimeout  out  1  one-cycle pulse on forced lock release

## Operation
- FSM states: IDLE, GRANT, ACK.
- IDLE:
  - select a requester; if none is selected, stay in IDLE.
  - → GRANT with the chosen requester's fields registered into `Addr`/`DataWrSW`/`Owner`.
- GRANT:
  - `Wr`=1 only if the request is a write and Addr < NUM_REGS.
  - capture `RegRdData` (or 8'hFF if out of range) into the owner's RdData at the end of the cycle.
  - → ACK.
- ACK:
  - owner's Ack=1; owner's Err updated.
  - lock state updated: lock held if the owner's Lock=1, released if Lock=0.
  - → IDLE.
- Selection, unlocked:
  - only one Req high → grant it.
  - both high → grant the requester not in LastGnt; LastGnt updates on every grant.
- Selection, locked: only the lock owner's Req is accepted; the other requester waits.
- Lock timer:
  - increments in every IDLE cycle while locked and the owner's Req=0.
  - clears on each grant.
  - at LOCK_MAX: lock released, `LockTimeout` pulses, and normal arbitration resumes in the next IDLE cycle.
- Write data is the requester's write data unmodified; bit masking is the register file's job.
- Read data for a write access is the pre-write register value.
- Out-of-range access: no `Wr`, RdData=8'hFF, Err=1, lock still updated.
- `Addr`/`DataWrSW`/`Owner` hold their last value outside GRANT, so the register read mux stays stable.

## Timing
- Req high in IDLE at cycle n → GRANT at n+1 (`Wr` pulse at n+1) → Ack at n+2 → IDLE at n+3.
- Throughput: one access per 3 cycles.
- Requesters drop Req in cycle n+3; a Req still high in IDLE is a new request.
- RdData/Err are valid from the Ack cycle and hold until that requester's next Ack.
- Reset values, from the cycle after an edge with PciReset=1:
  - FSM=IDLE.
  - all Acks, `Wr`, `Busy`, `LockTimeout`, Errs = 0.
  - `Addr`, `DataWrSW`, RdData = 0.
  - `Owner`=0, LastGnt=Bmc (Host wins the first tie), unlocked, timer=0.
- Reset mid-access aborts it: no Ack is ever issued for that access. If reset coincides with GRANT, the `Wr` strobe of that cycle still occurs (registered); nothing after it does.
- A Req arriving in GRANT/ACK waits; it is evaluated in the next IDLE.

## Structure
- Package `lpc_pkg`:
  - state enum {IDLE, GRANT, ACK}.
  - requester ID enum {REQ_HOST, REQ_BMC}.
  - LPC_NUM_REGS = 32.
  - RD_ERR_DATA = 8'hFF.
- Sub-module `lpc_arb_lock_timer`:
  - 8-bit idle counter with clear/enable.
  - produces the expire pulse.
- Everything else lives in one FSM module.

## Test plan
- Host write 8'h5A to addr 8'h0E with Bmc idle → `Wr`=1 with `Addr`=8'h0E, `DataWrSW`=8'h5A at n+1; HostAck at n+2; HostRdData = old value; HostErr=0.
- Both request in the same cycle after reset → Host granted first, Bmc immediately after; with both held continuously, grants alternate H,B,H,B.
- Bmc reads addr 8'h25 → no `Wr`; BmcRdData=8'hFF; BmcErr=1; BmcAck one cycle.
- Bmc read 8'h09 with Lock=1 while Host requests, then Bmc write 8'h09 with Lock=0 → Host waits through both Bmc accesses and is granted in the IDLE after the second BmcAck.
- Bmc locks, then idles with Host requesting → `LockTimeout` pulses after LOCK_MAX idle cycles and Host is granted next cycle.
- PciReset=1 during GRANT → no Ack; all outputs at reset values the next cycle; a new Host request completes normally afterwards.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared types and constants for the LPC register-file access arbiter.
package lpc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } lpc_state_e;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_BMC  = 1'b1
  } lpc_req_e;

  localparam int         LPC_NUM_REGS = 32;
  localparam logic [7:0] RD_ERR_DATA  = 8'hFF;

endpackage

// File: rtl/lpc_arb_lock_timer.sv
// Idle counter for a held bus lock; expire_o is high while the count sits at LOCK_MAX.
module lpc_arb_lock_timer
  import lpc_pkg::*;
#(
  parameter logic [7:0] LOCK_MAX = 8'd64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] count_q, count_d;

  assign expire_o = (count_q == LOCK_MAX);

  // Expiry restarts the count so the pulse lasts exactly one cycle.
  always_comb begin
    count_d = count_q;
    if (clr_i || expire_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lpc_reg_arbiter.sv
// Two-requester (Host/Bmc) arbiter for the single LPC register-file port:
// round-robin with optional lock, out-of-range error response.
module lpc_reg_arbiter
  import lpc_pkg::*;
#(
  parameter int NUM_REGS = LPC_NUM_REGS,
  parameter int LOCK_MAX = 64
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       HostReq,
  input  logic       HostWr,
  input  logic       HostLock,
  input  logic [7:0] HostAddr,
  input  logic [7:0] HostWrData,
  output logic       HostAck,
  output logic [7:0] HostRdData,
  output logic       HostErr,
  input  logic       BmcReq,
  input  logic       BmcWr,
  input  logic       BmcLock,
  input  logic [7:0] BmcAddr,
  input  logic [7:0] BmcWrData,
  output logic       BmcAck,
  output logic [7:0] BmcRdData,
  output logic       BmcErr,
  input  logic [7:0] RegRdData,
  output logic [7:0] Addr,
  output logic       Wr,
  output logic [7:0] DataWrSW,
  output logic       Busy,
  output logic       Owner,
  output logic       LockTimeout,
  output lpc_state_e DbgState
);

  // Handshake: a requester raises Req with Wr/Lock/Addr/WrData stable and holds
  // it until a one-cycle Ack; Req still high in IDLE after Ack is a new request.

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  lpc_state_e state_q, state_d;
  lpc_req_e   owner_q, owner_d, last_gnt_q, last_gnt_d, gnt_sel;
  logic       lock_q, lock_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d;
  logic       wr_q, wr_d, in_range_q, in_range_d;
  logic [7:0] host_rd_q, host_rd_d, bmc_rd_q, bmc_rd_d;
  logic       host_err_q, host_err_d, bmc_err_q, bmc_err_d;
  logic       host_ok, bmc_ok, gnt_valid;
  logic       sel_wr, sel_in_range;
  logic [7:0] sel_addr, sel_wdata;
  logic       owner_req, owner_lock, lock_expire, timer_en, timer_clr;

  // While locked only the lock owner (the last grantee) may be selected.
  assign host_ok   = HostReq && (!lock_q || owner_q == REQ_HOST);
  assign bmc_ok    = BmcReq  && (!lock_q || owner_q == REQ_BMC);
  assign gnt_valid = (state_q == IDLE) && (host_ok || bmc_ok);

  always_comb begin
    gnt_sel = REQ_HOST;
    if (host_ok && bmc_ok) begin
      gnt_sel = (last_gnt_q == REQ_HOST) ? REQ_BMC : REQ_HOST;
    end else if (bmc_ok) begin
      gnt_sel = REQ_BMC;
    end
  end

  assign sel_wr       = (gnt_sel == REQ_BMC) ? BmcWr     : HostWr;
  assign sel_addr     = (gnt_sel == REQ_BMC) ? BmcAddr   : HostAddr;
  assign sel_wdata    = (gnt_sel == REQ_BMC) ? BmcWrData : HostWrData;
  assign sel_in_range = ({1'b0, sel_addr} < NUM_REGS_W);

  assign owner_req  = (owner_q == REQ_BMC) ? BmcReq  : HostReq;
  assign owner_lock = (owner_q == REQ_BMC) ? BmcLock : HostLock;
  assign timer_en   = (state_q == IDLE) && lock_q && !owner_req;
  assign timer_clr  = gnt_valid || !lock_q;

  lpc_arb_lock_timer #(
    .LOCK_MAX (8'(LOCK_MAX))
  ) u_lock_timer (
    .clk_i    (LpcClock),
    .rst_i    (PciReset),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expire_o (lock_expire)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    lock_d     = lock_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = 1'b0;
    in_range_d = in_range_q;
    host_rd_d  = host_rd_q;
    bmc_rd_d   = bmc_rd_q;
    host_err_d = host_err_q;
    bmc_err_d  = bmc_err_q;
    unique case (state_q)
      IDLE: begin
        if (lock_expire) lock_d = 1'b0;
        if (gnt_valid) begin
          state_d    = GRANT;
          owner_d    = gnt_sel;
          last_gnt_d = gnt_sel;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          in_range_d = sel_in_range;
          wr_d       = sel_wr && sel_in_range;
        end
      end
      GRANT: begin
        state_d = ACK;
        // RegRdData still reflects the pre-write value while Wr is asserted.
        if (owner_q == REQ_BMC) begin
          bmc_rd_d  = in_range_q ? RegRdData : RD_ERR_DATA;
          bmc_err_d = !in_range_q;
        end else begin
          host_rd_d  = in_range_q ? RegRdData : RD_ERR_DATA;
          host_err_d = !in_range_q;
        end
      end
      ACK: begin
        state_d = IDLE;
        lock_d  = owner_lock;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state_q    <= IDLE;
      owner_q    <= REQ_HOST;
      last_gnt_q <= REQ_BMC;
      lock_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      in_range_q <= 1'b0;
      host_rd_q  <= '0;
      bmc_rd_q   <= '0;
      host_err_q <= 1'b0;
      bmc_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      lock_q     <= lock_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      in_range_q <= in_range_d;
      host_rd_q  <= host_rd_d;
      bmc_rd_q   <= bmc_rd_d;
      host_err_q <= host_err_d;
      bmc_err_q  <= bmc_err_d;
    end
  end

  assign HostAck     = (state_q == ACK) && (owner_q == REQ_HOST);
  assign BmcAck      = (state_q == ACK) && (owner_q == REQ_BMC);
  assign HostRdData  = host_rd_q;
  assign BmcRdData   = bmc_rd_q;
  assign HostErr     = host_err_q;
  assign BmcErr      = bmc_err_q;
  assign Addr        = addr_q;
  assign DataWrSW    = wdata_q;
  assign Wr          = wr_q;
  assign Busy        = (state_q != IDLE);
  assign Owner       = owner_q;
  assign LockTimeout = lock_expire;
  assign DbgState    = state_q;

endmodule

// File: tb/tb_lpc_reg_arbiter.sv
// Self-checking bench for lpc_reg_arbiter with a 32-byte register file model.
module tb_lpc_reg_arbiter;
  import lpc_pkg::*;

  localparam int LOCK_MAX = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_req = 0, host_wr = 0, host_lock = 0;
  logic [7:0] host_addr = 0, host_wdata = 0;
  logic       bmc_req = 0, bmc_wr = 0, bmc_lock = 0;
  logic [7:0] bmc_addr = 0, bmc_wdata = 0;
  logic       HostAck, BmcAck, HostErr, BmcErr, Wr, Busy, Owner, LockTimeout;
  logic [7:0] HostRdData, BmcRdData, Addr, DataWrSW, RegRdData;
  lpc_state_e DbgState;

  logic [7:0]  rf[32];
  logic [7:0]  shadow[32];
  logic [9:0]  exp_q[$];
  logic [15:0] exp_wr_q[$];
  logic [9:0]  mon_e;
  logic [15:0] mon_w;
  int n_cmp = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  lpc_reg_arbiter #(.NUM_REGS(32), .LOCK_MAX(LOCK_MAX)) dut (
    .LpcClock(clk), .PciReset(rst),
    .HostReq(host_req), .HostWr(host_wr), .HostLock(host_lock),
    .HostAddr(host_addr), .HostWrData(host_wdata),
    .HostAck(HostAck), .HostRdData(HostRdData), .HostErr(HostErr),
    .BmcReq(bmc_req), .BmcWr(bmc_wr), .BmcLock(bmc_lock),
    .BmcAddr(bmc_addr), .BmcWrData(bmc_wdata),
    .BmcAck(BmcAck), .BmcRdData(BmcRdData), .BmcErr(BmcErr),
    .RegRdData(RegRdData), .Addr(Addr), .Wr(Wr), .DataWrSW(DataWrSW),
    .Busy(Busy), .Owner(Owner), .LockTimeout(LockTimeout), .DbgState(DbgState)
  );

  // register file model
  assign RegRdData = (Addr < 8'd32) ? rf[Addr[4:0]] : 8'h3C;
  always @(posedge clk) if (Wr && Addr < 8'd32) rf[Addr[4:0]] <= DataWrSW;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: ack results {who, err, rddata} and write strobes {addr, data}
  always @(negedge clk) begin
    if (HostAck || BmcAck) begin
      check("single_ack", 32'(HostAck & BmcAck), 32'(0));
      check("ack_pending", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("ack_result",
              32'({BmcAck, BmcAck ? BmcErr : HostErr, BmcAck ? BmcRdData : HostRdData}),
              32'(mon_e));
      end
    end
    if (Wr) begin
      check("wr_pending", 32'(exp_wr_q.size() != 0), 32'(1));
      if (exp_wr_q.size() != 0) begin
        mon_w = exp_wr_q.pop_front();
        check("wr_strobe", 32'({Addr, DataWrSW}), 32'(mon_w));
      end
    end
  end

  // driver tasks
  task automatic push_exp(input logic who, input logic wr, input logic [7:0] addr,
                          input logic [7:0] data);
    logic       in_r;
    logic [7:0] rd;
    in_r = (addr < 8'd32);
    rd   = in_r ? shadow[addr[4:0]] : 8'hFF;
    exp_q.push_back({who, ~in_r, rd});
    if (wr && in_r) begin
      exp_wr_q.push_back({addr, data});
      shadow[addr[4:0]] = data;
    end
  endtask

  task automatic drive_req(input logic who, input logic wr, input logic lock,
                           input logic [7:0] addr, input logic [7:0] data);
    if (who) begin
      bmc_req = 1; bmc_wr = wr; bmc_lock = lock; bmc_addr = addr; bmc_wdata = data;
    end else begin
      host_req = 1; host_wr = wr; host_lock = lock; host_addr = addr; host_wdata = data;
    end
  endtask

  task automatic drop_req(input logic who);
    if (who) bmc_req = 0;
    else host_req = 0;
  endtask

  task automatic wait_ack(input logic who);
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (who ? BmcAck : HostAck) seen = 1;
    end
    check("ack_arrives", 32'(seen), 32'(1));
  endtask

  task automatic access(input logic who, input logic wr, input logic lock,
                        input logic [7:0] addr, input logic [7:0] data);
    push_exp(who, wr, addr, data);
    @(posedge clk); #1 drive_req(who, wr, lock, addr, data);
    wait_ack(who);
    @(posedge clk); #1 drop_req(who);
  endtask

  task automatic check_reset_vals();
    check("rst_state", 32'(DbgState), 32'(IDLE));
    check("rst_strobes", 32'({HostAck, BmcAck, Wr, Busy, LockTimeout, HostErr, BmcErr, Owner}), 32'(0));
    check("rst_addr_data", 32'({Addr, DataWrSW}), 32'(0));
    check("rst_rddata", 32'({HostRdData, BmcRdData}), 32'(0));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_reset_vals();
  endtask

  int cyc;
  bit found;
  int n_acks;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i]     = 8'($urandom);
      shadow[i] = rf[i];
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_reset_vals();

    // host write with exact cycle timing
    push_exp(1'b0, 1'b1, 8'h0E, 8'h5A);
    @(posedge clk); #1 drive_req(1'b0, 1'b1, 1'b0, 8'h0E, 8'h5A);
    @(negedge clk);
    check("t1_idle_n", 32'(Busy), 32'(0));
    @(negedge clk);
    check("t1_grant", 32'({Wr, Busy, Owner, Addr, DataWrSW}), 32'({1'b1, 1'b1, 1'b0, 8'h0E, 8'h5A}));
    @(negedge clk);
    check("t1_ack", 32'({HostAck, HostErr, Wr}), 32'({1'b1, 1'b0, 1'b0}));
    @(posedge clk); #1 drop_req(1'b0);
    @(negedge clk);
    check("t1_idle_n3", 32'(Busy), 32'(0));

    // simultaneous requests after reset alternate H,B,H,B
    apply_reset();
    push_exp(1'b0, 1'b0, 8'h01, 8'h00);
    push_exp(1'b1, 1'b0, 8'h02, 8'h00);
    push_exp(1'b0, 1'b0, 8'h01, 8'h00);
    push_exp(1'b1, 1'b0, 8'h02, 8'h00);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 1'b0, 8'h01, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
    n_acks = 0;
    for (int i = 0; i < 40 && n_acks < 4; i++) begin
      @(negedge clk);
      if (HostAck || BmcAck) n_acks++;
    end
    check("t2_ack_count", 32'(n_acks), 32'(4));
    @(posedge clk); #1 drop_req(1'b0); drop_req(1'b1);

    // out-of-range bmc read
    access(1'b1, 1'b0, 1'b0, 8'h25, 8'h00);
    @(negedge clk);
    check("t3_err_hold", 32'({BmcErr, BmcRdData, HostErr}), 32'({1'b1, 8'hFF, 1'b0}));

    // locked read-modify-write by bmc while host waits
    push_exp(1'b1, 1'b0, 8'h09, 8'h00);
    push_exp(1'b1, 1'b1, 8'h09, 8'hC3);
    push_exp(1'b0, 1'b0, 8'h03, 8'h00);
    @(posedge clk); #1 drive_req(1'b1, 1'b0, 1'b1, 8'h09, 8'h00);
    @(posedge clk); #1 drive_req(1'b0, 1'b0, 1'b0, 8'h03, 8'h00);
    wait_ack(1'b1);
    @(posedge clk); #1 drop_req(1'b1);
    @(posedge clk); #1 drive_req(1'b1, 1'b1, 1'b0, 8'h09, 8'hC3);
    wait_ack(1'b1);
    @(posedge clk); #1 drop_req(1'b1);
    @(negedge clk);
    check("t4_idle_after_unlock", 32'(Busy), 32'(0));
    @(negedge clk);
    check("t4_host_granted", 32'({Busy, Owner}), 32'(2'b10));
    wait_ack(1'b0);
    @(posedge clk); #1 drop_req(1'b0);

    // unused lock is force-released after LOCK_MAX idle cycles
    push_exp(1'b1, 1'b0, 8'h11, 8'h00);
    push_exp(1'b0, 1'b0, 8'h04, 8'h00);
    @(posedge clk); #1 drive_req(1'b1, 1'b0, 1'b1, 8'h11, 8'h00);
    wait_ack(1'b1);
    @(posedge clk); #1 drop_req(1'b1); drive_req(1'b0, 1'b0, 1'b0, 8'h04, 8'h00);
    found = 0;
    cyc = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      if (LockTimeout) begin
        found = 1;
        cyc = i;
      end
    end
    check("t5_timeout_cycle", 32'(cyc), 32'(LOCK_MAX + 1));
    @(negedge clk);
    check("t5_one_shot", 32'({LockTimeout, Busy}), 32'(0));
    @(negedge clk);
    check("t5_host_granted", 32'({Busy, Owner}), 32'(2'b10));
    wait_ack(1'b0);
    @(posedge clk); #1 drop_req(1'b0);

    // reset during GRANT: the registered write lands, no ack follows
    exp_wr_q.push_back({8'h07, 8'h99});
    shadow[7] = 8'h99;
    @(posedge clk); #1 drive_req(1'b0, 1'b1, 1'b0, 8'h07, 8'h99);
    @(posedge clk); #1 rst = 1; drop_req(1'b0);
    @(negedge clk);
    check("t6_wr_in_reset", 32'({Wr, Addr}), 32'({1'b1, 8'h07}));
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check_reset_vals();
    access(1'b0, 1'b0, 1'b0, 8'h07, 8'h00);

    // random single-requester traffic, including out-of-range addresses
    for (int k = 0; k < 10; k++) begin
      access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
             8'($urandom_range(0, 39)), 8'($urandom));
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    check("exp_wr_q_drained", 32'(exp_wr_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
